// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Package : mc_pkg
// Desc    : Shared defaults, width helpers and channel-state type for the
//           multi-channel sample-history buffer.
// Rev     : 1.0 - initial release
// ============================================================================
package mc_pkg;

    localparam int c_def_num_ch = 7;
    localparam int c_def_width  = 8;
    localparam int c_def_depth  = 10;

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width that holds the sum of depth samples of width bits exactly
    function automatic int sum_width(input int width, input int depth);
        return width + $clog2(depth + 1);
    endfunction

    localparam int c_def_tap_w = clog2_min1(c_def_depth);
    localparam int c_def_sum_w = sum_width(c_def_width, c_def_depth);

    // Bookkeeping of one channel at the default geometry
    typedef struct packed {
        logic [c_def_tap_w-1:0] wr_ptr;
        logic [c_def_tap_w:0]   fill;
        logic [c_def_sum_w-1:0] sum;
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/mc_sample_window_if.sv
`default_nettype none
// ============================================================================
// Interface : mc_sample_window_if
// Desc      : Sample / clear / read request bus and read response bus of the
//             multi-channel sample-history buffer.
// Rev       : 1.0 - initial release
// ============================================================================
interface mc_sample_window_if #(
    parameter  int NUM_CH = mc_pkg::c_def_num_ch,
    parameter  int WIDTH  = mc_pkg::c_def_width,
    parameter  int DEPTH  = mc_pkg::c_def_depth,
    localparam int CH_W   = mc_pkg::clog2_min1(NUM_CH),
    localparam int TAP_W  = mc_pkg::clog2_min1(DEPTH),
    localparam int SUM_W  = mc_pkg::sum_width(WIDTH, DEPTH)
) ();

    logic             in_valid;
    logic [CH_W-1:0]  in_chan;
    logic [WIDTH-1:0] in_data;
    logic             clr_valid;
    logic [CH_W-1:0]  clr_chan;
    logic             rd_valid;
    logic [CH_W-1:0]  rd_chan;
    logic [TAP_W-1:0] rd_tap;
    logic             rd_data_valid;
    logic [WIDTH-1:0] rd_data;
    logic [SUM_W-1:0] rd_sum;
    logic [TAP_W:0]   rd_fill;
    logic             err;
    logic             drop;

    modport master (
        output in_valid, in_chan, in_data, clr_valid, clr_chan,
               rd_valid, rd_chan, rd_tap,
        input  rd_data_valid, rd_data, rd_sum, rd_fill, err, drop
    );

    modport slave (
        input  in_valid, in_chan, in_data, clr_valid, clr_chan,
               rd_valid, rd_chan, rd_tap,
        output rd_data_valid, rd_data, rd_sum, rd_fill, err, drop
    );

endinterface
`default_nettype wire

// File: rtl/mc_window_ch.sv
`default_nettype none
// ============================================================================
// Module : mc_window_ch
// Desc   : One channel: circular buffer of the last DEPTH samples with write
//          pointer, saturating fill count and exact running window sum.
//          Tap readback is combinational; the top registers it.
// Rev    : 1.0 - initial release
// ============================================================================
module mc_window_ch #(
    parameter  int WIDTH = mc_pkg::c_def_width,
    parameter  int DEPTH = mc_pkg::c_def_depth,
    localparam int TAP_W = mc_pkg::clog2_min1(DEPTH),
    localparam int SUM_W = mc_pkg::sum_width(WIDTH, DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             clr,
    input  wire logic [TAP_W-1:0] rd_tap,
    output logic      [WIDTH-1:0] tap_data,
    output logic      [SUM_W-1:0] sum,
    output logic      [TAP_W:0]   fill
);

    localparam logic [TAP_W-1:0] c_last  = TAP_W'(DEPTH - 1);
    localparam logic [TAP_W:0]   c_depth = (TAP_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [TAP_W-1:0] r_wr_ptr;
    logic [TAP_W:0]   r_fill;
    logic [SUM_W-1:0] r_sum;

    logic             w_full;
    logic [SUM_W-1:0] w_evict;
    logic [TAP_W:0]   w_idx_raw;
    logic [TAP_W-1:0] w_idx;

    // Oldest sample leaves the window only once the buffer is full
    always_comb begin
        w_full  = (r_fill == c_depth);
        w_evict = w_full ? SUM_W'(r_mem[r_wr_ptr]) : '0;
    end

    // Pointer, fill and sum; a clear resets bookkeeping but leaves storage
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_sum    <= '0;
        end else if (wr_en) begin
            r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
            r_sum <= r_sum + SUM_W'(wr_data) - w_evict;
        end
    end

    // Sample storage, zeroed only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Tap address (wr_ptr-1-tap) mod DEPTH; out-of-range taps read as zero
    always_comb begin
        w_idx_raw = {1'b0, r_wr_ptr} + c_depth - (TAP_W + 1)'(1) - {1'b0, rd_tap};
        if (w_idx_raw >= c_depth) begin
            w_idx = TAP_W'(w_idx_raw - c_depth);
        end else begin
            w_idx = w_idx_raw[TAP_W-1:0];
        end
        if (w_idx > c_last) begin
            w_idx = '0;
        end
        tap_data = ({1'b0, rd_tap} < r_fill) ? r_mem[w_idx] : '0;
        sum      = r_sum;
        fill     = r_fill;
    end

endmodule
`default_nettype wire

// File: rtl/mc_sample_window.sv
`default_nettype none
// ============================================================================
// Module : mc_sample_window
// Desc   : Multi-channel sample-history buffer. Decodes strobes, arbitrates
//          same-channel clear against write, muxes and registers the read
//          response, and flags illegal requests and dropped samples.
// Rev    : 1.0 - initial release
// ============================================================================
module mc_sample_window #(
    parameter  int NUM_CH = mc_pkg::c_def_num_ch,
    parameter  int WIDTH  = mc_pkg::c_def_width,
    parameter  int DEPTH  = mc_pkg::c_def_depth,
    localparam int CH_W   = mc_pkg::clog2_min1(NUM_CH),
    localparam int TAP_W  = mc_pkg::clog2_min1(DEPTH),
    localparam int SUM_W  = mc_pkg::sum_width(WIDTH, DEPTH)
) (
    input wire logic           clk,
    input wire logic           rst_n,
    mc_sample_window_if.slave  bus
);

    import mc_pkg::*;

    localparam logic [CH_W:0]  c_num_ch = (CH_W + 1)'(NUM_CH);
    localparam logic [TAP_W:0] c_depth  = (TAP_W + 1)'(DEPTH);

    logic              w_in_chan_ok, w_clr_chan_ok, w_rd_chan_ok, w_tap_ok;
    logic              w_in_ok, w_clr_ok, w_rd_ok, w_collide, w_err;
    logic [NUM_CH-1:0] w_wr_en, w_clr;
    logic [WIDTH-1:0]  w_ch_data [NUM_CH];
    logic [SUM_W-1:0]  w_ch_sum  [NUM_CH];
    logic [TAP_W:0]    w_ch_fill [NUM_CH];
    logic [WIDTH-1:0]  w_sel_data;
    logic [SUM_W-1:0]  w_sel_sum;
    logic [TAP_W:0]    w_sel_fill;

    logic              r_rd_data_valid, r_err, r_drop;
    logic [WIDTH-1:0]  r_rd_data;
    logic [SUM_W-1:0]  r_rd_sum;
    logic [TAP_W:0]    r_rd_fill;

    // Strobe legality, per-channel enables; a clear beats a write to its channel
    always_comb begin
        w_in_chan_ok  = ({1'b0, bus.in_chan}  < c_num_ch);
        w_clr_chan_ok = ({1'b0, bus.clr_chan} < c_num_ch);
        w_rd_chan_ok  = ({1'b0, bus.rd_chan}  < c_num_ch);
        w_tap_ok      = ({1'b0, bus.rd_tap}   < c_depth);
        w_in_ok       = bus.in_valid  && w_in_chan_ok;
        w_clr_ok      = bus.clr_valid && w_clr_chan_ok;
        w_rd_ok       = bus.rd_valid  && w_rd_chan_ok && w_tap_ok;
        w_collide     = w_in_ok && w_clr_ok && (bus.in_chan == bus.clr_chan);
        w_err         = (bus.in_valid  && !w_in_chan_ok)
                     || (bus.clr_valid && !w_clr_chan_ok)
                     || (bus.rd_valid  && !(w_rd_chan_ok && w_tap_ok));
        for (int c = 0; c < NUM_CH; c++) begin
            w_clr[c]   = w_clr_ok && (bus.clr_chan == CH_W'(c));
            w_wr_en[c] = w_in_ok && (bus.in_chan == CH_W'(c)) && !w_clr[c];
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            mc_window_ch #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (w_wr_en[g]),
                .wr_data  (bus.in_data),
                .clr      (w_clr[g]),
                .rd_tap   (bus.rd_tap),
                .tap_data (w_ch_data[g]),
                .sum      (w_ch_sum[g]),
                .fill     (w_ch_fill[g])
            );
        end
    endgenerate

    // Pick the addressed channel's pre-update view (read-before-write)
    always_comb begin
        w_sel_data = '0;
        w_sel_sum  = '0;
        w_sel_fill = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.rd_chan == CH_W'(c)) begin
                w_sel_data = w_ch_data[c];
                w_sel_sum  = w_ch_sum[c];
                w_sel_fill = w_ch_fill[c];
            end
        end
    end

    // One-cycle read response; illegal reads answer with zeros, idle holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data_valid <= 1'b0;
            r_err           <= 1'b0;
            r_drop          <= 1'b0;
            r_rd_data       <= '0;
            r_rd_sum        <= '0;
            r_rd_fill       <= '0;
        end else begin
            r_rd_data_valid <= bus.rd_valid;
            r_err           <= w_err;
            r_drop          <= w_collide;
            if (bus.rd_valid) begin
                r_rd_data <= w_rd_ok ? w_sel_data : '0;
                r_rd_sum  <= w_rd_ok ? w_sel_sum  : '0;
                r_rd_fill <= w_rd_ok ? w_sel_fill : '0;
            end
        end
    end

    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_sum        = r_rd_sum;
    assign bus.rd_fill       = r_rd_fill;
    assign bus.err           = r_err;
    assign bus.drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mc_sample_window.sv
`default_nettype none
// ============================================================================
// Module : tb_mc_sample_window
// Desc   : Self-checking bench: directed vector table, reset sequence and
//          random traffic compared against a queue-based window model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_sample_window;

    localparam int NUM_CH = 7;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int CH_W   = mc_pkg::clog2_min1(NUM_CH);
    localparam int TAP_W  = mc_pkg::clog2_min1(DEPTH);

    typedef struct {
        bit in_v;  int in_ch;  int in_d;
        bit clr_v; int clr_ch;
        bit rd_v;  int rd_ch;  int rd_tap;
        bit chk;   int e_data; int e_sum; int e_fill;
        bit e_err; bit e_drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: per channel, newest sample at index 0, at most DEPTH kept
    int q [NUM_CH][$];
    int m_data = 0, m_sum = 0, m_fill = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    mc_sample_window_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mc_sample_window #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic vec_t mk(bit iv, int ic, int id, bit cv, int cc, bit rv, int rc,
                                int rt, bit chk, int ed, int es, int ef, bit ee, bit edr);
        vec_t v;
        v.in_v = iv;  v.in_ch = ic;  v.in_d = id;
        v.clr_v = cv; v.clr_ch = cc;
        v.rd_v = rv;  v.rd_ch = rc;  v.rd_tap = rt;
        v.chk = chk;  v.e_data = ed; v.e_sum = es; v.e_fill = ef;
        v.e_err = ee; v.e_drop = edr;
        return v;
    endfunction

    function automatic vec_t wr(int c, int d);
        return mk(1, c, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t rdx(int c, int t, int d, int s, int f, bit e);
        return mk(0, 0, 0, 0, 0, 1, c, t, 1, d, s, f, e, 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;  bus.in_chan = '0;  bus.in_data = '0;
        bus.clr_valid = 1'b0; bus.clr_chan = '0;
        bus.rd_valid = 1'b0;  bus.rd_chan = '0;  bus.rd_tap = '0;
    endtask

    // Apply one cycle; use_tab selects table constants or the model as reference
    task automatic step(input vec_t v, input bit use_tab);
        bit in_ok, clr_ok, rd_ok, e_err, e_drop;
        int s;
        in_ok  = v.in_v  && (v.in_ch  < NUM_CH);
        clr_ok = v.clr_v && (v.clr_ch < NUM_CH);
        rd_ok  = v.rd_v  && (v.rd_ch  < NUM_CH) && (v.rd_tap < DEPTH);
        e_err  = (v.in_v && v.in_ch >= NUM_CH) || (v.clr_v && v.clr_ch >= NUM_CH)
              || (v.rd_v && !rd_ok);
        e_drop = in_ok && clr_ok && (v.in_ch == v.clr_ch);
        if (v.rd_v) begin
            if (rd_ok) begin
                s = 0;
                foreach (q[v.rd_ch][k]) s += q[v.rd_ch][k];
                m_sum  = s;
                m_fill = q[v.rd_ch].size();
                m_data = (v.rd_tap < q[v.rd_ch].size()) ? q[v.rd_ch][v.rd_tap] : 0;
            end else begin
                m_data = 0; m_sum = 0; m_fill = 0;
            end
        end
        if (clr_ok) q[v.clr_ch].delete();
        if (in_ok && !e_drop) begin
            q[v.in_ch].push_front(v.in_d);
            if (q[v.in_ch].size() > DEPTH) void'(q[v.in_ch].pop_back());
        end
        bus.in_valid = v.in_v;   bus.in_chan = CH_W'(v.in_ch);  bus.in_data = WIDTH'(v.in_d);
        bus.clr_valid = v.clr_v; bus.clr_chan = CH_W'(v.clr_ch);
        bus.rd_valid = v.rd_v;   bus.rd_chan = CH_W'(v.rd_ch);  bus.rd_tap = TAP_W'(v.rd_tap);
        @(posedge clk);
        #1;
        check("rd_data_valid", int'(bus.rd_data_valid), int'(v.rd_v));
        if (use_tab) begin
            check("err", int'(bus.err), int'(v.e_err));
            check("drop", int'(bus.drop), int'(v.e_drop));
            if (v.chk) begin
                check("rd_data", int'(bus.rd_data), v.e_data);
                check("rd_sum", int'(bus.rd_sum), v.e_sum);
                check("rd_fill", int'(bus.rd_fill), v.e_fill);
            end
        end else begin
            check("err_model", int'(bus.err), int'(e_err));
            check("drop_model", int'(bus.drop), int'(e_drop));
            check("rd_data_model", int'(bus.rd_data), m_data);
            check("rd_sum_model", int'(bus.rd_sum), m_sum);
            check("rd_fill_model", int'(bus.rd_fill), m_fill);
        end
    endtask

    // One reset cycle with a pending read; every output must read zero after it
    task automatic do_reset();
        idle();
        bus.rd_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rd_data_valid", int'(bus.rd_data_valid), 0);
        check("rst_rd_data", int'(bus.rd_data), 0);
        check("rst_rd_sum", int'(bus.rd_sum), 0);
        check("rst_rd_fill", int'(bus.rd_fill), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_drop", int'(bus.drop), 0);
        for (int c = 0; c < NUM_CH; c++) q[c].delete();
        m_data = 0; m_sum = 0; m_fill = 0;
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset();

        tab.push_back(rdx(0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) tab.push_back(wr(2, i));
        tab.push_back(rdx(2, 0, 3, 6, 3, 0));
        tab.push_back(rdx(2, 1, 2, 6, 3, 0));
        tab.push_back(rdx(2, 2, 1, 6, 3, 0));
        tab.push_back(rdx(2, 3, 0, 6, 3, 0));
        for (int i = 1; i <= 12; i++) tab.push_back(wr(6, 10 * i));
        tab.push_back(rdx(6, 0, 120, 750, 10, 0));
        tab.push_back(rdx(6, 9, 30, 750, 10, 0));
        for (int i = 0; i < 10; i++) tab.push_back(wr(1, 255));
        tab.push_back(rdx(1, 0, 255, 2550, 10, 0));
        tab.push_back(rdx(1, 9, 255, 2550, 10, 0));
        tab.push_back(mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(rdx(1, 0, 0, 0, 0, 0));
        tab.push_back(wr(3, 4));
        tab.push_back(mk(1, 3, 7, 0, 0, 1, 3, 0, 1, 4, 4, 1, 0, 0));
        tab.push_back(rdx(3, 0, 7, 11, 2, 0));
        tab.push_back(mk(1, 7, 99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab.push_back(rdx(3, 10, 0, 0, 0, 1));
        tab.push_back(rdx(3, 0, 7, 11, 2, 0));
        tab.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab.push_back(rdx(7, 0, 0, 0, 0, 1));
        tab.push_back(rdx(3, 1, 4, 11, 2, 0));
        tab.push_back(mk(1, 6, 130, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(rdx(2, 0, 0, 0, 0, 0));
        tab.push_back(rdx(6, 0, 130, 850, 10, 0));
        tab.push_back(rdx(6, 9, 40, 850, 10, 0));

        foreach (tab[i]) step(tab[i], 1'b1);

        // Mid-stream reset discards all history in every channel
        step(wr(4, 33), 1'b1);
        step(wr(0, 17), 1'b1);
        do_reset();
        for (int c = 0; c < NUM_CH; c++) step(rdx(c, 0, 0, 0, 0, 0), 1'b1);

        // Random traffic against the model, including illegal indices
        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 11),
                   0, 0, 0, 0, 0, 0);
            step(v, 1'b0);
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
